// File: rtl/vector_pkg.sv
// Shared constants and types for the vector multiply unit.
package vector_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/vector_mul_lane.sv
// Shared signed lane multiplier, combinational.
// Build option VECTOR_MUL_SAT_EN: clamp products to the signed WIDTH range instead of wrapping.
module vector_mul_lane #(
    parameter int unsigned WIDTH = vector_pkg::WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic        [WIDTH-1:0] r
);

`ifdef VECTOR_MUL_SAT_EN
    localparam logic signed [2*WIDTH-1:0] PROD_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PROD_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;

    assign prod = a * b;

    always_comb begin
        r = prod[WIDTH-1:0];
        if (prod > PROD_MAX) begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (prod < PROD_MIN) begin
            r = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    // The low WIDTH bits of the full signed product are all that is kept.
    assign r = a * b;
`endif

endmodule

// File: rtl/vector_mul_unit.sv
// Four-lane signed vector multiplier using one shared multiplier, one lane per cycle.
// Build option VECTOR_MUL_SAT_EN selects saturating lane products (see vector_mul_lane).
module vector_mul_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] b3,
    input  logic             res_ready,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3
);
    import vector_pkg::*;

    state_t           state_q, state_d;
    lane_idx_t        cnt_q, cnt_d;
    logic             capture;
    logic [WIDTH-1:0] a_in [LANES];
    logic [WIDTH-1:0] b_in [LANES];
    logic [WIDTH-1:0] a_q  [LANES];
    logic [WIDTH-1:0] b_q  [LANES];
    logic [WIDTH-1:0] r_q  [LANES];
    logic [WIDTH-1:0] prod;

    assign a_in[0] = a0;
    assign a_in[1] = a1;
    assign a_in[2] = a2;
    assign a_in[3] = a3;
    assign b_in[0] = b0;
    assign b_in[1] = b1;
    assign b_in[2] = b2;
    assign b_in[3] = b3;

    vector_mul_lane #(
        .WIDTH(WIDTH)
    ) u_lane (
        .a(a_q[cnt_q]),
        .b(b_q[cnt_q]),
        .r(prod)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                cnt_d = lane_idx_t'(cnt_q + 1'b1);
                if (cnt_q == lane_idx_t'(LANES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // start only counts once the current result is handed off.
                if (res_ready) begin
                    if (start) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                for (int i = 0; i < LANES; i++) begin
                    a_q[i] <= a_in[i];
                    b_q[i] <= b_in[i];
                end
            end
            if (state_q == MUL) begin
                r_q[cnt_q] <= prod;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign r0        = r_q[0];
    assign r1        = r_q[1];
    assign r2        = r_q[2];
    assign r3        = r_q[3];

endmodule

// File: tb/tb_vector_mul_unit.sv
// Self-checking bench for vector_mul_unit; expected results queued at launch, compared at res_valid.
module tb_vector_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic        res_ready;
    logic        busy;
    logic        res_valid;
    logic [31:0] r0, r1, r2, r3;

    int errors = 0;
    int checks = 0;
    logic [127:0] sb_q[$];

    vector_mul_unit #(
        .WIDTH(32),
        .LANES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .res_ready(res_ready),
        .busy(busy),
        .res_valid(res_valid),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane_model(logic [31:0] x, logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
`ifdef VECTOR_MUL_SAT_EN
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
        return p[31:0];
    endfunction

    function automatic logic [127:0] vec_model(logic [127:0] av, logic [127:0] bv);
        logic [127:0] res;
        for (int i = 0; i < 4; i++) res[32*i +: 32] = lane_model(av[32*i +: 32], bv[32*i +: 32]);
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] outs();
        return {r3, r2, r1, r0};
    endfunction

    task automatic drive_ops(input logic [127:0] av, input logic [127:0] bv);
        a0 = av[31:0];  a1 = av[63:32];  a2 = av[95:64];  a3 = av[127:96];
        b0 = bv[31:0];  b1 = bv[63:32];  b2 = bv[95:64];  b3 = bv[127:96];
    endtask

    // Returns just after the edge that samples start.
    task automatic launch(input logic [127:0] av, input logic [127:0] bv, input logic [127:0] exp);
        @(posedge clk); #1;
        drive_ops(av, bv);
        start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pop_expected(output logic [127:0] exp);
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else exp = 'x;
    endtask

    localparam logic [127:0] A29 = {32'd82, 32'd74, 32'd45, 32'd15};
    localparam logic [127:0] B29 = {32'd83, 32'd75, 32'd46, 32'd16};
    localparam logic [127:0] R29 = {32'd6806, 32'd5550, 32'd2070, 32'd240};

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
        drive_ops({4{32'hDEAD_BEEF}}, {4{32'h1234_5678}});
        #12;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        if (busy !== 1'b0) errors++;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", res_valid);
        end
        checks++;
        if (outs() !== 128'd0) begin
            errors++; $display("FAIL reset_r: got %h expected 0", outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        logic [127:0] exp;
        res_ready = 1'b1;
        launch(A29, B29, R29);
        wait_valid(n);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL basic_latency: got %0d cycles expected 4", n);
        end
        pop_expected(exp);
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL basic_result: got %h expected %h", outs(), exp);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy=%b valid=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_hold();
        int n;
        logic [127:0] exp;
        res_ready = 1'b0;
        launch(A29, B29, R29);
        wait_valid(n);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL hold_latency: got %0d cycles expected 4", n);
        end
        pop_expected(exp);
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL hold_result: got %h expected %h", outs(), exp);
        end
        for (int i = 0; i < 10; i++) begin
            drive_ops(rnd128(), rnd128());
            start = i[0];
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || outs() !== R29) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b r=%h expected 1 %h", res_valid, outs(), R29);
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] exp;
        res_ready = 1'b0;
        launch(A29, B29, R29);
        wait_valid(n);
        pop_expected(exp);
        checks++;
        if (n !== 4 || outs() !== exp) begin
            errors++; $display("FAIL b2b_first: got n=%0d r=%h expected 4 %h", n, outs(), exp);
        end
        drive_ops({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
        start = 1'b1;
        res_ready = 1'b1;
        sb_q.push_back({32'd32, 32'd21, 32'd12, 32'd5});
        @(posedge clk); #1;
        start = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_no_bubble: got busy=%b valid=%b expected 1 0", busy, res_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (r0 !== 32'd5 || r1 !== 32'd2070 || r3 !== 32'd6806) begin
            errors++; $display("FAIL b2b_retain: got r0=%0d r1=%0d r3=%0d expected 5 2070 6806", r0, r1, r3);
        end
        wait_valid(n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL b2b_latency: got %0d more cycles expected 3", n);
        end
        pop_expected(exp);
        checks++;
        if (outs() !== exp) begin
            errors++; $display("FAIL b2b_result: got %h expected %h", outs(), exp);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int n;
        logic [127:0] exp;
        logic [127:0] av;
        logic [127:0] bv;
        av = {32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_0000, 32'h7FFF_FFFF};
        bv = {32'h8000_0000, 32'd7,         32'd65536,     32'd2};
`ifdef VECTOR_MUL_SAT_EN
        exp = {32'h7FFF_FFFF, 32'hFFFF_FFEB, 32'h8000_0000, 32'h7FFF_FFFF};
`else
        exp = {32'h0000_0000, 32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFE};
`endif
        res_ready = 1'b1;
        launch(av, bv, exp);
        wait_valid(n);
        pop_expected(exp);
        checks++;
        if (n !== 4 || outs() !== exp) begin
            errors++; $display("FAIL saturation: got n=%0d r=%h expected 4 %h", n, outs(), exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int n;
        logic [127:0] exp;
        logic [127:0] av;
        logic [127:0] bv;
        logic seen;
        res_ready = 1'b1;
        av = {32'd9, 32'd8, 32'd7, 32'd6};
        bv = {32'd3, 32'd3, 32'd3, 32'd3};
        launch(av, bv, vec_model(av, bv));
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || outs() !== 128'd0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b valid=%b r=%h expected 0 0 0", busy, res_valid, outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_result: got valid seen=%b expected 0", seen);
        end
        av = {32'd100, 32'hFFFF_FFFF, 32'd0, 32'd12345};
        bv = {32'd200, 32'd55, 32'd77, 32'd3};
        launch(av, bv, vec_model(av, bv));
        wait_valid(n);
        pop_expected(exp);
        checks++;
        if (n !== 4 || outs() !== exp) begin
            errors++; $display("FAIL abort_recover: got n=%0d r=%h expected 4 %h", n, outs(), exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_isolation();
        logic [127:0] exp;
        logic [127:0] av;
        logic [127:0] bv;
        res_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            av = rnd128();
            bv = rnd128();
            launch(av, bv, vec_model(av, bv));
            drive_ops(rnd128(), rnd128());
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                drive_ops(rnd128(), rnd128());
            end
            pop_expected(exp);
            checks++;
            if (res_valid !== 1'b1 || outs() !== exp) begin
                errors++;
                $display("FAIL isolation_%0d: got valid=%b r=%h expected 1 %h", t, res_valid, outs(), exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_reset_abort();
        test_operand_isolation();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: got %0d left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
